// File: rtl/gan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gan_pkg
//  Description : Shared constants and types for the generator pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package gan_pkg;

    // Q8.8 fixed-point element format used between generator layers
    localparam int GAN_DATA_W    = 16;
    localparam int GAN_FRAC_BITS = 8;
    localparam int GAN_N_HIDDEN  = 256;

    typedef logic signed [GAN_DATA_W-1:0] q88_t;

endpackage : gan_pkg
`default_nettype wire

// File: rtl/leaky_relu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : leaky_relu_lane
//  Description : One combinational LeakyReLU lane. Negative inputs are scaled
//                by 2^-LEAK_SHIFT with an arithmetic shift (floor toward
//                -inf); non-negative inputs pass unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module leaky_relu_lane
    import gan_pkg::*;
#(
    parameter int DATA_W     = GAN_DATA_W,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y,
    output logic                     is_neg
);

    // Sign bit alone decides the branch; the shift cannot overflow since |y| <= |x|
    always_comb begin
        is_neg = x[DATA_W-1];
        y      = is_neg ? (x >>> LEAK_SHIFT) : x;
    end

endmodule : leaky_relu_lane
`default_nettype wire

// File: rtl/layer2_leaky_relu.sv
`default_nettype none
// ============================================================================
//  Module      : layer2_leaky_relu
//  Description : Sequential LeakyReLU stage. Captures a full pre-activation
//                frame on start, activates LANES elements per cycle into the
//                output register, counts negative inputs and pulses done when
//                the last group has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer2_leaky_relu
    import gan_pkg::*;
#(
    parameter int N_ELEM     = GAN_N_HIDDEN,
    parameter int DATA_W     = GAN_DATA_W,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DATA_W*N_ELEM-1:0]   flat_input_flat,
    output logic [DATA_W*N_ELEM-1:0]   flat_output_flat,
    output logic [$clog2(N_ELEM):0]    neg_count,
    output logic                       busy,
    output logic                       done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_n_grp      = N_ELEM / LANES;
    localparam int c_grp_w      = (c_n_grp > 1) ? $clog2(c_n_grp) : 1;
    localparam int c_grp_bits   = DATA_W * LANES;
    localparam int c_cnt_w      = $clog2(N_ELEM) + 1;
    localparam int c_lane_cnt_w = $clog2(LANES) + 1;

    localparam logic [c_grp_w-1:0] c_last_grp = c_grp_w'(c_n_grp - 1);

    // FSM encoding
    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]                 r_state;
    logic [c_grp_w-1:0]         r_grp_idx;
    logic [c_cnt_w-1:0]         r_run_cnt;
    logic [c_cnt_w-1:0]         r_neg_count;
    logic [DATA_W*N_ELEM-1:0]   r_in_buf;
    logic [DATA_W*N_ELEM-1:0]   r_out;
    logic                       r_busy;
    logic                       r_done;

    // ------------------------------------------------------------------------
    // Datapath: current group of LANES elements through the lane array
    // ------------------------------------------------------------------------
    logic [c_grp_bits-1:0]      w_grp_x;
    logic [c_grp_bits-1:0]      w_grp_y;
    logic [LANES-1:0]           w_is_neg;
    logic [c_lane_cnt_w-1:0]    w_grp_neg;
    logic                       w_accept;

    assign w_accept = (r_state == c_idle) && start;
    assign w_grp_x  = r_in_buf[int'(r_grp_idx) * c_grp_bits +: c_grp_bits];

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            leaky_relu_lane #(
                .DATA_W     (DATA_W),
                .LEAK_SHIFT (LEAK_SHIFT)
            ) u_lane (
                .x      (w_grp_x[k*DATA_W +: DATA_W]),
                .y      (w_grp_y[k*DATA_W +: DATA_W]),
                .is_neg (w_is_neg[k])
            );
        end
    endgenerate

    // Population count of negative lanes in the current group
    always_comb begin
        w_grp_neg = '0;
        for (int k = 0; k < LANES; k++) begin
            w_grp_neg = w_grp_neg + c_lane_cnt_w'(w_is_neg[k]);
        end
    end

    // Frame capture; the buffer is pure data so it carries no reset
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_in_buf <= flat_input_flat;
        end
    end

    // Control FSM, negative counter and group-wise output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_grp_idx   <= '0;
            r_run_cnt   <= '0;
            r_neg_count <= '0;
            r_out       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_grp_idx <= '0;
                        r_run_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_run;
                    end
                end
                c_run: begin
                    r_out[int'(r_grp_idx) * c_grp_bits +: c_grp_bits] <= w_grp_y;
                    r_run_cnt <= r_run_cnt + c_cnt_w'(w_grp_neg);
                    if (r_grp_idx == c_last_grp) begin
                        r_neg_count <= r_run_cnt + c_cnt_w'(w_grp_neg);
                        r_grp_idx   <= '0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_idle;
                    end else begin
                        r_grp_idx <= r_grp_idx + c_grp_w'(1);
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign flat_output_flat = r_out;
    assign neg_count        = r_neg_count;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule : layer2_leaky_relu
`default_nettype wire

// File: tb/tb_layer2_leaky_relu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer2_leaky_relu
//  Description : Self-checking bench for layer2_leaky_relu: default build plus
//                LANES=1 / LANES=16 builds with LEAK_SHIFT=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer2_leaky_relu;

    localparam int N  = 256;
    localparam int W  = 16;
    localparam int BW = N * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    start_v = '0;
    logic [BW-1:0] din_v [3];

    wire [BW-1:0] dout0, dout1, dout2;
    wire [8:0]    neg0, neg1, neg2;
    wire          busy0, busy1, busy2;
    wire          done0, done1, done2;

    int n_cmp = 0;
    int n_bad = 0;

    layer2_leaky_relu u_d0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .flat_input_flat(din_v[0]),
        .flat_output_flat(dout0), .neg_count(neg0), .busy(busy0), .done(done0));

    layer2_leaky_relu #(.LANES(1), .LEAK_SHIFT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .flat_input_flat(din_v[1]),
        .flat_output_flat(dout1), .neg_count(neg1), .busy(busy1), .done(done1));

    layer2_leaky_relu #(.LANES(16), .LEAK_SHIFT(1)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .flat_input_flat(din_v[2]),
        .flat_output_flat(dout2), .neg_count(neg2), .busy(busy2), .done(done2));

    function automatic logic [BW-1:0] get_out(input int d);
        case (d) 0: return dout0; 1: return dout1; default: return dout2; endcase
    endfunction
    function automatic logic [8:0] get_neg(input int d);
        case (d) 0: return neg0; 1: return neg1; default: return neg2; endcase
    endfunction
    function automatic logic get_busy(input int d);
        case (d) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_done(input int d);
        case (d) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction

    // Reference: floor(x / 2^sh) for negatives, computed on magnitudes
    function automatic logic [W-1:0] ref_act(input logic [W-1:0] x, input int sh);
        int xi;
        int m;
        xi = int'($signed(x));
        if (xi >= 0) return x;
        m = ((-xi) + (1 << sh) - 1) / (1 << sh);
        return W'(-m);
    endfunction

    function automatic logic [BW-1:0] rand_frame();
        logic [BW-1:0] f;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 7))
                0:       f[i*W +: W] = 16'h8000;
                1:       f[i*W +: W] = 16'hFFFF;
                2:       f[i*W +: W] = 16'h0000;
                3:       f[i*W +: W] = 16'h7FFF;
                default: f[i*W +: W] = W'($urandom);
            endcase
        end
        return f;
    endfunction

    function automatic logic [BW-1:0] fill_frame(input logic [W-1:0] v);
        logic [BW-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = v;
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pulse start for one edge, then count cycles from the accept edge to done
    task automatic start_and_wait(input int d, input int bound, output int lat);
        start_v[d] = 1'b1;
        tick;
        start_v[d] = 1'b0;
        chk($sformatf("busy after accept d%0d", d), 32'(get_busy(d)), 32'd1);
        lat = 0;
        while (!get_done(d) && lat < bound) begin
            tick;
            lat++;
            if (!get_done(d) && lat == bound - 1) begin
                chk($sformatf("busy before done d%0d", d), 32'(get_busy(d)), 32'd0);
            end
        end
    endtask

    task automatic check_ref(input int d, input int sh, input logic [BW-1:0] in, input string tag);
        logic [BW-1:0] o;
        int nn;
        o  = get_out(d);
        nn = 0;
        for (int i = 0; i < N; i++) begin
            if ($signed(in[i*W +: W]) < 0) nn++;
            chk($sformatf("%s elem%0d", tag, i), 32'(o[i*W +: W]), 32'(ref_act(in[i*W +: W], sh)));
        end
        chk($sformatf("%s neg_count", tag), 32'(get_neg(d)), 32'(nn));
    endtask

    task automatic run_ref(input int d, input int sh, input int exp_lat, input string tag);
        int lat;
        din_v[d] = rand_frame();
        start_and_wait(d, exp_lat + 20, lat);
        chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s busy at done", tag), 32'(get_busy(d)), 32'd0);
        check_ref(d, sh, din_v[d], tag);
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    initial begin
        vec_t tbl [10];
        logic [BW-1:0] o;
        int lat;
        int cnt;
        int tneg;

        tbl[0] = '{16'h0000, 16'h0000};
        tbl[1] = '{16'hFFFF, 16'hFFFF};
        tbl[2] = '{16'hFFF8, 16'hFFFF};
        tbl[3] = '{16'h7FFF, 16'h7FFF};
        tbl[4] = '{16'hFF00, 16'hFFE0};
        tbl[5] = '{16'h8000, 16'hF000};
        tbl[6] = '{16'h0100, 16'h0100};
        tbl[7] = '{16'hFFF7, 16'hFFFE};
        tbl[8] = '{16'h0001, 16'h0001};
        tbl[9] = '{16'hFFF0, 16'hFFFE};

        for (int d = 0; d < 3; d++) din_v[d] = '0;

        // Reset state
        rst = 1'b1;
        tick; tick; tick;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset out zero d%0d", d), 32'(get_out(d) == '0), 32'd1);
            chk($sformatf("reset neg d%0d", d), 32'(get_neg(d)), 32'd0);
            chk($sformatf("reset busy d%0d", d), 32'(get_busy(d)), 32'd0);
            chk($sformatf("reset done d%0d", d), 32'(get_done(d)), 32'd0);
        end

        // Table-driven rounding / zero / extremes
        tneg = 0;
        for (int i = 0; i < N; i++) begin
            din_v[0][i*W +: W] = tbl[i % 10].x;
            if (tbl[i % 10].x[W-1]) tneg++;
        end
        start_and_wait(0, 84, lat);
        chk("table latency", 32'(lat), 32'd64);
        o = dout0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("table elem%0d x=%0h", i, tbl[i % 10].x), 32'(o[i*W +: W]), 32'(tbl[i % 10].y));
        end
        chk("table neg_count", 32'(neg0), 32'(tneg));

        // Mixed frame with one-cycle done check
        din_v[0] = fill_frame(16'h0100);
        din_v[0][5*W +: W]   = 16'hFF00;
        din_v[0][255*W +: W] = 16'h8000;
        start_and_wait(0, 84, lat);
        chk("mixed latency", 32'(lat), 32'd64);
        chk("mixed elem5", 32'(dout0[5*W +: W]), 32'h0000FFE0);
        chk("mixed elem255", 32'(dout0[255*W +: W]), 32'h0000F000);
        chk("mixed elem0", 32'(dout0[0 +: W]), 32'h00000100);
        chk("mixed elem254", 32'(dout0[254*W +: W]), 32'h00000100);
        chk("mixed neg_count", 32'(neg0), 32'd2);
        tick;
        chk("done one cycle wide", 32'(done0), 32'd0);

        // Start while busy is ignored
        din_v[0] = fill_frame(16'h0200);
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        lat = 0;
        for (int i = 0; i < 9; i++) begin tick; lat++; end
        din_v[0]   = fill_frame(16'h8000);
        start_v[0] = 1'b1;
        tick; lat++;
        start_v[0] = 1'b0;
        while (!done0 && lat < 100) begin tick; lat++; end
        chk("busy-start latency", 32'(lat), 32'd64);
        chk("busy-start out all 0200", 32'(dout0 == fill_frame(16'h0200)), 32'd1);
        chk("busy-start neg_count", 32'(neg0), 32'd0);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin tick; if (done0) cnt++; end
        chk("busy-start extra done", 32'(cnt), 32'd0);

        // Back-to-back frames: second start in the done cycle
        din_v[0] = rand_frame();
        start_and_wait(0, 84, lat);
        chk("b2b first latency", 32'(lat), 32'd64);
        check_ref(0, 3, din_v[0], "b2b first");
        din_v[0] = fill_frame(16'hFE00);
        start_and_wait(0, 84, lat);
        chk("b2b second latency", 32'(lat), 32'd64);
        chk("b2b out all FFC0", 32'(dout0 == fill_frame(16'hFFC0)), 32'd1);
        chk("b2b neg_count", 32'(neg0), 32'd256);

        // Reset mid-frame
        din_v[0] = rand_frame();
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        for (int i = 0; i < 30; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midreset out zero", 32'(dout0 == '0), 32'd1);
        chk("midreset busy", 32'(busy0), 32'd0);
        chk("midreset neg", 32'(neg0), 32'd0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin tick; if (done0) cnt++; end
        chk("midreset no done", 32'(cnt), 32'd0);
        run_ref(0, 3, 64, "after reset");

        // Parameter sweep against the reference model
        run_ref(1, 1, 256, "lanes1 f0");
        run_ref(1, 1, 256, "lanes1 f1");
        run_ref(2, 1, 16, "lanes16 f0");
        run_ref(2, 1, 16, "lanes16 f1");
        run_ref(0, 3, 64, "lanes4 rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_layer2_leaky_relu
`default_nettype wire
